// File: rtl/keypad_bin_entry.sv
// keypad_bin_entry: 4x4 keypad scanner and debouncer feeding a two-digit BCD entry that
// commits its binary value into operand register A or B.
module keypad_bin_entry #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       resetn,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       a_valid,
    output logic       b_valid,
    output logic [3:0] ent_tens,
    output logic [3:0] ent_ones,
    output logic [1:0] ent_cnt,
    output logic       key_strobe,
    output logic       err
);
    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DwellLast = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CntDone = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic [1:0] {StIdle, StPressChk, StHeld, StRelChk} state_e;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [1:0]    k_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    hit_code_q, hit_code_d;
    logic [1:0]    col_hits, col_row;
    logic          sample, sweep_done, sweep_key;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          fire;
    logic          key_strobe_q;
    logic [3:0]    kcode_q;

    logic          is_digit, is_clear, is_load, load_b;
    logic [3:0]    digit;
    logic [6:0]    value;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d, a_q, a_d, b_q, b_d;
    logic [1:0]    ecnt_q, ecnt_d;
    logic          a_valid_q, a_valid_d, b_valid_q, b_valid_d, err_q, err_d;

    assign col    = ~(4'b0001 << k_q);
    assign sample = (dwell_q == DwellLast);

    // Per-column hit count merged into a sweep-wide count saturating at 2 (MULTI).
    always_comb begin
        col_hits   = 2'd0;
        col_row    = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
                col_row = 2'(r);
            end
        end
        hits_d     = hits_q;
        hit_code_d = hit_code_q;
        if (col_hits != 2'd0) begin
            hits_d     = (hits_q != 2'd0 || col_hits == 2'd2) ? 2'd2 : 2'd1;
            hit_code_d = {col_row, k_q};
        end
        sweep_done = sample && (k_q == 2'd3);
        sweep_key  = sweep_done && (hits_d == 2'd1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            row_s1_q   <= 4'b1111;
            row_s2_q   <= 4'b1111;
            k_q        <= 2'd0;
            dwell_q    <= '0;
            hits_q     <= 2'd0;
            hit_code_q <= 4'd0;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
            if (sample) begin
                dwell_q <= '0;
                k_q     <= k_q + 2'd1;
                if (k_q == 2'd3) begin
                    hits_q     <= 2'd0;
                    hit_code_q <= 4'd0;
                end else begin
                    hits_q     <= hits_d;
                    hit_code_q <= hit_code_d;
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    // Debounce: only sweep results move the FSM; MULTI counts as no key.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        fire    = 1'b0;
        if (sweep_done) begin
            unique case (state_q)
                StIdle: begin
                    if (sweep_key) begin
                        key_d = hit_code_d;
                        cnt_d = CntOne;
                        if (CntOne == CntDone) begin
                            state_d = StHeld;
                            fire    = 1'b1;
                        end else begin
                            state_d = StPressChk;
                        end
                    end
                end
                StPressChk: begin
                    if (sweep_key && hit_code_d == key_q) begin
                        cnt_d = cnt_q + CntOne;
                        if (cnt_d == CntDone) begin
                            state_d = StHeld;
                            fire    = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (!sweep_key) begin
                        cnt_d   = CntOne;
                        state_d = (CntOne == CntDone) ? StIdle : StRelChk;
                    end
                end
                StRelChk: begin
                    if (sweep_key) begin
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                        if (cnt_d == CntDone) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            key_q        <= 4'd0;
            key_strobe_q <= 1'b0;
            kcode_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            key_strobe_q <= fire;
            if (fire) kcode_q <= key_d;
        end
    end

    // Key code is {row, col}; digits 1..9 sit in rows 0..2, columns 0..2.
    always_comb begin
        is_digit = 1'b0;
        is_clear = 1'b0;
        is_load  = 1'b0;
        load_b   = 1'b0;
        digit    = 4'd0;
        if (kcode_q[1:0] == 2'd3) begin
            is_load = (kcode_q[3:2] == 2'd0) || (kcode_q[3:2] == 2'd1);
            load_b  = (kcode_q[3:2] == 2'd1);
        end else if (kcode_q[3:2] == 2'd3) begin
            is_clear = (kcode_q[1:0] == 2'd0);
            is_digit = (kcode_q[1:0] == 2'd1);
        end else begin
            is_digit = 1'b1;
            digit    = {2'b00, kcode_q[3:2]} * 4'd3 + {2'b00, kcode_q[1:0]} + 4'd1;
        end
    end

    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        ecnt_d    = ecnt_q;
        a_d       = a_q;
        b_d       = b_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        err_d     = 1'b0;
        value     = {3'b000, tens_q} * 7'd10 + {3'b000, ones_q};
        if (key_strobe_q) begin
            if (is_digit) begin
                if (ecnt_q == 2'd2) begin
                    err_d = 1'b1;
                end else begin
                    tens_d = ones_q;
                    ones_d = digit;
                    ecnt_d = ecnt_q + 2'd1;
                end
            end else if (is_clear || is_load) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                ecnt_d = 2'd0;
                if (is_load) begin
                    if (ecnt_q == 2'd0 || value > 7'd15) begin
                        err_d = 1'b1;
                    end else if (load_b) begin
                        b_d       = value[3:0];
                        b_valid_d = 1'b1;
                    end else begin
                        a_d       = value[3:0];
                        a_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            ecnt_q    <= 2'd0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            ecnt_q    <= ecnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            err_q     <= err_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign a_valid    = a_valid_q;
    assign b_valid    = b_valid_q;
    assign ent_tens   = tens_q;
    assign ent_ones   = ones_q;
    assign ent_cnt    = ecnt_q;
    assign key_strobe = key_strobe_q;
    assign err        = err_q;

endmodule

// File: tb/tb_keypad_bin_entry.sv
// Directed bench for keypad_bin_entry: SCAN_DIV=4, DEBOUNCE=3 (16-clock sweeps) with a
// keypad model that pulls a row low when a pressed key's column is driven.
module tb_keypad_bin_entry;
    localparam int SWEEP = 16;
    localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6, KB = 7;
    localparam int K7 = 8, K9 = 10, KSTAR = 12, KHASH = 14;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] col, row, A, B, ent_tens, ent_ones;
    logic [1:0] ent_cnt;
    logic       a_valid, b_valid, key_strobe, err;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_strobe = 0, n_err = 0, strobe_cyc = -1, err_cyc = -1;

    keypad_bin_entry #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clock(clock), .resetn(resetn), .col(col), .row(row), .A(A), .B(B),
        .a_valid(a_valid), .b_valid(b_valid), .ent_tens(ent_tens), .ent_ones(ent_ones),
        .ent_cnt(ent_cnt), .key_strobe(key_strobe), .err(err)
    );

    always #5 clock = ~clock;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Edges since reset release; sweeps end on multiples of SWEEP.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (key_strobe) begin n_strobe++; strobe_cyc = cyc; end
            if (err) begin n_err++; err_cyc = cyc; end
        end
    end

    task automatic align();
        do begin @(posedge clock); #1; end while (cyc % SWEEP != 0);
    endtask

    task automatic run_sweeps(input int n);
        repeat (n * SWEEP) @(posedge clock);
        #1;
    endtask

    task automatic tap(input int k);
        align();
        pressed = 16'h0000;
        pressed[k] = 1'b1;
        run_sweeps(4);
        pressed = 16'h0000;
        run_sweeps(4);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #21;
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL rst_col got=%b want=1110", col); end
        checks++; if ({A, B, a_valid, b_valid} !== 10'd0) begin failures++; $display("FAIL rst_ops got A=%0d B=%0d av=%b bv=%b want 0", A, B, a_valid, b_valid); end
        checks++; if ({ent_tens, ent_ones, ent_cnt, key_strobe, err} !== 12'd0) begin failures++; $display("FAIL rst_entry got t=%0d o=%0d c=%0d ks=%b e=%b want 0", ent_tens, ent_ones, ent_cnt, key_strobe, err); end
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_hold();
        int s, e0;
        align();
        s = n_strobe; e0 = cyc;
        pressed = 16'h0000; pressed[K7] = 1'b1;
        run_sweeps(5);
        checks++; if (n_strobe - s !== 1) begin failures++; $display("FAIL hold_strobes got=%0d want=1", n_strobe - s); end
        checks++; if (strobe_cyc !== e0 + 48) begin failures++; $display("FAIL hold_time got=%0d want=%0d", strobe_cyc, e0 + 48); end
        checks++; if (ent_ones !== 4'd7 || ent_tens !== 4'd0 || ent_cnt !== 2'd1) begin failures++; $display("FAIL hold_entry got t=%0d o=%0d c=%0d want 0/7/1", ent_tens, ent_ones, ent_cnt); end
        pressed = 16'h0000;
        run_sweeps(4);
    endtask

    task automatic test_load_a();
        tap(KSTAR);
        checks++; if (ent_cnt !== 2'd0 || ent_ones !== 4'd0) begin failures++; $display("FAIL clr_entry got o=%0d c=%0d want 0/0", ent_ones, ent_cnt); end
        tap(K1); tap(K2);
        checks++; if (ent_tens !== 4'd1 || ent_ones !== 4'd2 || ent_cnt !== 2'd2) begin failures++; $display("FAIL a_digits got t=%0d o=%0d c=%0d want 1/2/2", ent_tens, ent_ones, ent_cnt); end
        tap(KA);
        checks++; if (A !== 4'd12 || a_valid !== 1'b1) begin failures++; $display("FAIL a_load got A=%0d av=%b want 12/1", A, a_valid); end
        checks++; if (ent_cnt !== 2'd0 || ent_tens !== 4'd0 || ent_ones !== 4'd0) begin failures++; $display("FAIL a_clear got t=%0d o=%0d c=%0d want 0", ent_tens, ent_ones, ent_cnt); end
        checks++; if (n_err !== 0) begin failures++; $display("FAIL a_noerr got=%0d want=0", n_err); end
    endtask

    task automatic test_range_b();
        int e;
        e = n_err;
        tap(K1); tap(K6); tap(KB);
        checks++; if (n_err !== e + 1) begin failures++; $display("FAIL b16_err got=%0d want=%0d", n_err, e + 1); end
        checks++; if (err_cyc !== strobe_cyc + 1) begin failures++; $display("FAIL b16_errtime got=%0d want=%0d", err_cyc, strobe_cyc + 1); end
        checks++; if (B !== 4'd0 || b_valid !== 1'b0 || ent_cnt !== 2'd0) begin failures++; $display("FAIL b16_keep got B=%0d bv=%b c=%0d want 0/0/0", B, b_valid, ent_cnt); end
        tap(K9); tap(KB);
        checks++; if (B !== 4'd9 || b_valid !== 1'b1 || n_err !== e + 1) begin failures++; $display("FAIL b9_load got B=%0d bv=%b errs=%0d want 9/1/%0d", B, b_valid, n_err, e + 1); end
    endtask

    task automatic test_overflow();
        int e;
        e = n_err;
        tap(K3); tap(K4); tap(K5);
        checks++; if (n_err !== e + 1) begin failures++; $display("FAIL ovf_err got=%0d want=%0d", n_err, e + 1); end
        checks++; if (ent_tens !== 4'd3 || ent_ones !== 4'd4 || ent_cnt !== 2'd2) begin failures++; $display("FAIL ovf_entry got t=%0d o=%0d c=%0d want 3/4/2", ent_tens, ent_ones, ent_cnt); end
        tap(KSTAR); tap(KA);
        checks++; if (n_err !== e + 2 || A !== 4'd12 || a_valid !== 1'b1) begin failures++; $display("FAIL empty_a got errs=%0d A=%0d av=%b want %0d/12/1", n_err, A, a_valid, e + 2); end
    endtask

    task automatic test_bounce();
        int s, e, e0;
        align();
        s = n_strobe; e0 = cyc;
        pressed = 16'h0000; pressed[K5] = 1'b1; run_sweeps(2);
        pressed = 16'h0000; run_sweeps(1);
        pressed[K5] = 1'b1; run_sweeps(4);
        checks++; if (n_strobe !== s + 1 || strobe_cyc !== e0 + 96) begin failures++; $display("FAIL bounce got n=%0d t=%0d want %0d/%0d", n_strobe, strobe_cyc, s + 1, e0 + 96); end
        checks++; if (ent_ones !== 4'd5 || ent_cnt !== 2'd1) begin failures++; $display("FAIL bounce_entry got o=%0d c=%0d want 5/1", ent_ones, ent_cnt); end
        pressed = 16'h0000; run_sweeps(4);
        align();
        s = n_strobe;
        pressed[K1] = 1'b1; pressed[K2] = 1'b1; run_sweeps(5);
        pressed = 16'h0000; run_sweeps(4);
        checks++; if (n_strobe !== s || ent_cnt !== 2'd1) begin failures++; $display("FAIL multi got n=%0d c=%0d want %0d/1", n_strobe, ent_cnt, s); end
        s = n_strobe; e = n_err;
        tap(KHASH);
        checks++; if (n_strobe !== s + 1 || n_err !== e || ent_ones !== 4'd5 || ent_cnt !== 2'd1) begin failures++; $display("FAIL hash got n=%0d errs=%0d o=%0d c=%0d want %0d/%0d/5/1", n_strobe, n_err, ent_ones, ent_cnt, s + 1, e); end
    endtask

    task automatic test_reset_mid();
        int s;
        align();
        pressed = 16'h0000; pressed[K7] = 1'b1;
        run_sweeps(2);
        repeat (3) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++; if (col !== 4'b1110) begin failures++; $display("FAIL mid_col got=%b want=1110", col); end
        checks++; if ({A, B, a_valid, b_valid, ent_tens, ent_ones, ent_cnt, key_strobe, err} !== 22'd0) begin failures++; $display("FAIL mid_outs got A=%0d av=%b c=%0d want 0", A, a_valid, ent_cnt); end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        s = n_strobe;
        repeat (4 * SWEEP) @(posedge clock);
        #1;
        checks++; if (n_strobe !== s + 1 || strobe_cyc !== 48) begin failures++; $display("FAIL mid_redeb got n=%0d t=%0d want %0d/48", n_strobe, strobe_cyc, s + 1); end
        checks++; if (ent_ones !== 4'd7 || ent_cnt !== 2'd1 || A !== 4'd0 || a_valid !== 1'b0) begin failures++; $display("FAIL mid_entry got o=%0d c=%0d A=%0d av=%b want 7/1/0/0", ent_ones, ent_cnt, A, a_valid); end
        pressed = 16'h0000;
        run_sweeps(4);
    endtask

    initial begin
        test_reset();
        test_hold();
        test_load_a();
        test_range_b();
        test_overflow();
        test_bounce();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
